// File: rtl/eeprom_cmd_sequencer_if.sv
// Bundle of request-side and I2C-controller-side signals for eeprom_cmd_sequencer.
// The slave modport is the sequencer. The master modport is its environment,
// which includes both the requester and the I2C controller.
interface eeprom_cmd_sequencer_if;
  logic        i_req;
  logic        i_rw;
  logic [15:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_rdata;
  logic [31:0] o_ctrl;
  logic [6:0]  o_dev_addr;
  logic [15:0] o_reg_addr;
  logic [31:0] o_w_data;
  logic [31:0] i_status;
  logic [7:0]  i_rd_data;
  logic [7:0]  i_rd_data_2;
  logic [7:0]  i_rd_data_3;
  logic [7:0]  i_rd_data_4;

  modport master (
    output i_req, i_rw, i_addr, i_wdata, i_status,
           i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4,
    input  o_busy, o_done, o_err, o_rdata, o_ctrl, o_dev_addr, o_reg_addr, o_w_data
  );

  modport slave (
    input  i_req, i_rw, i_addr, i_wdata, i_status,
           i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4,
    output o_busy, o_done, o_err, o_rdata, o_ctrl, o_dev_addr, o_reg_addr, o_w_data
  );
endinterface

// File: rtl/eeprom_cmd_sequencer.sv
// EEPROM command sequencer: turns single word read/write requests into one
// I2C controller transaction, with timeout supervision and an optional
// post-write wait for the EEPROM's internal write cycle.
// When the optional macro EEPROM_TWR_WAIT_EN is defined, successful writes
// wait TWR_CYCLES before completing. When it is undefined, the TWR state and
// its counter are absent.
module eeprom_cmd_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [2:0]  CLK_RATE       = 3'd7,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned TWR_CYCLES     = 500000
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  eeprom_cmd_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ISSUE    = 3'd1;
  localparam logic [2:0] S_WAIT_FIN = 3'd2;
  localparam logic [2:0] S_RELEASE  = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd5;
`ifdef EEPROM_TWR_WAIT_EN
  localparam logic [2:0]  S_TWR    = 3'd4;
  localparam logic [31:0] TWR_LAST = TWR_CYCLES - 1;
`endif
  localparam logic [31:0] TO_LAST = TIMEOUT_CYCLES - 1;

  logic [2:0]  state;
  logic        rw_lat;
  logic [15:0] addr_lat;
  logic [31:0] wdata_lat;
  logic        err_flag;
  logic [31:0] to_cnt;
`ifdef EEPROM_TWR_WAIT_EN
  logic [31:0] twr_cnt;
`else
  logic [31:0] unused_twr;
  assign unused_twr = TWR_CYCLES;
`endif

  logic       fin_s1, fin_s2, fin_prev;
  logic [7:0] st_s1, st_s2;
  logic       idle_prev;
  logic       fin_rise;
  logic       ctrl_idle;
  logic       unused_status;

  assign unused_status = &{1'b0, bus.i_status[31:10], bus.i_status[0]};
  assign fin_rise      = fin_s2 & ~fin_prev;
  assign ctrl_idle     = idle_prev && (st_s2 == 8'd0);
  assign bus.o_dev_addr = DEV_ADDR;

  // Two-flop synchronizers for finish and controller state, plus edge/idle history
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fin_s1    <= 1'b0;
      fin_s2    <= 1'b0;
      fin_prev  <= 1'b0;
      st_s1     <= 8'd0;
      st_s2     <= 8'd0;
      idle_prev <= 1'b0;
    end else begin
      fin_s1    <= bus.i_status[1];
      fin_s2    <= fin_s1;
      fin_prev  <= fin_s2;
      st_s1     <= bus.i_status[9:2];
      st_s2     <= st_s1;
      idle_prev <= (st_s2 == 8'd0);
    end
  end

  // Transaction FSM: issue, wait for finish or timeout, release, optional tWR, report
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= S_IDLE;
      rw_lat         <= 1'b0;
      addr_lat       <= 16'd0;
      wdata_lat      <= 32'd0;
      err_flag       <= 1'b0;
      to_cnt         <= 32'd0;
`ifdef EEPROM_TWR_WAIT_EN
      twr_cnt        <= 32'd0;
`endif
      bus.o_ctrl     <= 32'd0;
      bus.o_reg_addr <= 16'd0;
      bus.o_w_data   <= 32'd0;
      bus.o_rdata    <= 32'd0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
      bus.o_err      <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      bus.o_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_req && !bus.o_busy) begin
            rw_lat     <= bus.i_rw;
            addr_lat   <= bus.i_addr;
            wdata_lat  <= bus.i_wdata;
            err_flag   <= 1'b0;
            to_cnt     <= 32'd0;
            bus.o_busy <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.o_reg_addr <= addr_lat;
          bus.o_w_data   <= wdata_lat;
          bus.o_ctrl     <= {25'd0, CLK_RATE, 2'b00, rw_lat, 1'b1};
          to_cnt         <= to_cnt + 32'd1;
          state          <= S_WAIT_FIN;
        end
        S_WAIT_FIN: begin
          if (fin_rise) begin
            bus.o_ctrl[0] <= 1'b0;
            if (rw_lat) begin
              bus.o_rdata <= {bus.i_rd_data, bus.i_rd_data_2, bus.i_rd_data_3, bus.i_rd_data_4};
            end
            to_cnt <= 32'd0;
            state  <= S_RELEASE;
          end else if (to_cnt >= TO_LAST) begin
            err_flag      <= 1'b1;
            bus.o_ctrl[0] <= 1'b0;
            to_cnt        <= 32'd0;
            state         <= S_RELEASE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
        S_RELEASE: begin
          if (!fin_s2 && ctrl_idle) begin
`ifdef EEPROM_TWR_WAIT_EN
            if (!err_flag && !rw_lat) begin
              twr_cnt <= 32'd0;
              state   <= S_TWR;
            end else begin
              state <= S_DONE;
            end
`else
            state <= S_DONE;
`endif
          end else if (to_cnt >= TO_LAST) begin
            err_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
          end
        end
`ifdef EEPROM_TWR_WAIT_EN
        S_TWR: begin
          if (twr_cnt >= TWR_LAST) begin
            state <= S_DONE;
          end else begin
            twr_cnt <= twr_cnt + 32'd1;
          end
        end
`endif
        S_DONE: begin
          bus.o_done <= 1'b1;
          bus.o_err  <= err_flag;
          bus.o_busy <= 1'b0;
          err_flag   <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_cmd_sequencer.sv
// Self-checking bench for eeprom_cmd_sequencer with a behavioural I2C controller model.
// Completions are scored against a queue of expected results pushed as requests are driven.
module tb_eeprom_cmd_sequencer;

  localparam int unsigned TO_CYC  = 2000;
  localparam int unsigned TWR_CYC = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  eeprom_cmd_sequencer_if bus ();

  eeprom_cmd_sequencer #(
    .DEV_ADDR      (7'h50),
    .CLK_RATE      (3'd7),
    .TIMEOUT_CYCLES(TO_CYC),
    .TWR_CYCLES    (TWR_CYC)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          issue_cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          done_count = 0;
  int          last_done_cyc = 0;
  int          last_lat = 0;
  logic [31:0] model_rdata = 32'd0;

  logic        nack_mode = 1'b0;
  logic [7:0]  rd_b[4];
  logic [7:0]  rd_out[4];
  logic [7:0]  bus_q[$];
  int          txn_count = 0;
  logic [31:0] cap_ctrl = 32'd0;
  int          idle_cyc = 0;
  int          mphase = 0;
  int          mcnt = 0;
  logic        fin = 1'b0;
  logic [7:0]  mstate = 8'd0;

  assign bus.i_status    = {22'd0, mstate, fin, 1'b0};
  assign bus.i_rd_data   = rd_out[0];
  assign bus.i_rd_data_2 = rd_out[1];
  assign bus.i_rd_data_3 = rd_out[2];
  assign bus.i_rd_data_4 = rd_out[3];

  // Free-running cycle counter for latency measurements
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural I2C controller: capture the transfer, then finish (or stall on NACK)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mphase <= 0;
      mcnt   <= 0;
      fin    <= 1'b0;
      mstate <= 8'd0;
      for (int i = 0; i < 4; i++) rd_out[i] <= 8'd0;
    end else begin
      case (mphase)
        0: if (bus.o_ctrl[0]) begin
          bus_q.push_back({bus.o_dev_addr, 1'b0});
          bus_q.push_back(bus.o_reg_addr[15:8]);
          bus_q.push_back(bus.o_reg_addr[7:0]);
          if (bus.o_ctrl[3:1] == 3'd0) begin
            bus_q.push_back(bus.o_w_data[31:24]);
            bus_q.push_back(bus.o_w_data[23:16]);
            bus_q.push_back(bus.o_w_data[15:8]);
            bus_q.push_back(bus.o_w_data[7:0]);
          end else begin
            bus_q.push_back({bus.o_dev_addr, 1'b1});
          end
          txn_count <= txn_count + 1;
          cap_ctrl  <= bus.o_ctrl;
          mstate    <= 8'h03;
          mcnt      <= 0;
          mphase    <= 1;
        end
        1: begin
          mcnt <= mcnt + 1;
          if (mcnt == 20) begin
            if (nack_mode) begin
              mphase <= 4;
            end else begin
              for (int i = 0; i < 4; i++) rd_out[i] <= rd_b[i];
              fin    <= 1'b1;
              mphase <= 2;
            end
          end
        end
        2: if (!bus.o_ctrl[0]) begin
          fin    <= 1'b0;
          mcnt   <= 0;
          mphase <= 3;
        end
        3: begin
          mcnt <= mcnt + 1;
          if (mcnt == 3) begin
            mstate   <= 8'd0;
            idle_cyc <= cyc;
            mphase   <= 0;
          end
        end
        4: if (!bus.o_ctrl[0]) begin
          mcnt   <= 0;
          mphase <= 3;
        end
        default: mphase <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Scoreboard: every completion pulse pops one expectation and is compared against it
  always @(negedge clk) begin
    if (rst_n && bus.o_err && !bus.o_done) checkOutput("err_without_done", 64'(bus.o_err), 64'(0));
    if (rst_n && bus.o_done) begin
      done_count++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("done_err", 64'(bus.o_err), 64'(e.err));
        checkOutput("done_rdata", 64'(bus.o_rdata), 64'(e.rdata));
        checkOutput("done_busy_low", 64'(bus.o_busy), 64'(0));
        last_lat = cyc - e.issue_cyc;
      end
    end
  end

  task automatic applyStimulus(input logic rw, input logic [15:0] addr, input logic [31:0] wdata,
                               input logic expect_err, input logic push);
    exp_t e;
    @(posedge clk);
    #1;
    bus.i_req   = 1'b1;
    bus.i_rw    = rw;
    bus.i_addr  = addr;
    bus.i_wdata = wdata;
    if (push) begin
      if (rw && !expect_err) model_rdata = {rd_b[0], rd_b[1], rd_b[2], rd_b[3]};
      e.err       = expect_err;
      e.rdata     = model_rdata;
      e.issue_cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    checkOutput("busy_after_req", 64'(bus.o_busy), 64'(1));
  endtask

  task automatic waitDone(input int budget);
    int start;
    int n;
    start = done_count;
    n = 0;
    while (done_count == start && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_count == start) checkOutput("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic checkBytes(input string tag, input logic [7:0] expb[$]);
    checkOutput({tag, "_len"}, 64'(bus_q.size()), 64'(expb.size()));
    for (int i = 0; i < expb.size() && i < bus_q.size(); i++) begin
      checkOutput(tag, 64'(bus_q[i]), 64'(expb[i]));
    end
  endtask

  // Global watchdog so a hung DUT still ends the run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=hung expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int t0;
    logic [7:0] expb[$];
    bus.i_req = 1'b0;
    bus.i_rw = 1'b0;
    bus.i_addr = 16'd0;
    bus.i_wdata = 32'd0;
    rd_b[0] = 8'hDE; rd_b[1] = 8'hAD; rd_b[2] = 8'hBE; rd_b[3] = 8'hEF;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ctrl", 64'(bus.o_ctrl), 64'(0));
    checkOutput("rst_busy", 64'(bus.o_busy), 64'(0));
    checkOutput("rst_done", 64'(bus.o_done), 64'(0));
    checkOutput("rst_rdata", 64'(bus.o_rdata), 64'(0));
    checkOutput("dev_addr", 64'(bus.o_dev_addr), 64'(7'h50));
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    $display("[TB] write 0x0010 <= DEADBEEF");
    bus_q.delete();
    applyStimulus(1'b0, 16'h0010, 32'hDEADBEEF, 1'b0, 1'b1);
    waitDone(5000);
    expb = '{8'hA0, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    checkBytes("write_bytes", expb);
    checkOutput("write_ctrl_op", 64'(cap_ctrl[3:1]), 64'(0));
`ifdef EEPROM_TWR_WAIT_EN
    checkOutput("twr_wait", 64'((last_done_cyc - idle_cyc) >= int'(TWR_CYC)), 64'(1));
`else
    checkOutput("no_twr_latency", 64'((last_done_cyc - idle_cyc) <= 10), 64'(1));
`endif

    $display("[TB] read 0x0010");
    bus_q.delete();
    applyStimulus(1'b1, 16'h0010, 32'd0, 1'b0, 1'b1);
    waitDone(5000);
    expb = '{8'hA0, 8'h00, 8'h10, 8'hA1};
    checkBytes("read_bytes", expb);
    checkOutput("read_ctrl_op", 64'(cap_ctrl[3:1]), 64'(1));
    checkOutput("read_ctrl_rate", 64'(cap_ctrl[6:4]), 64'(7));
    checkOutput("read_ctrl_hi", 64'(cap_ctrl[31:7]), 64'(0));

    $display("[TB] random transactions");
    for (int k = 0; k < 4; k++) begin
      logic rw;
      rw = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) rd_b[i] = 8'($urandom);
      applyStimulus(rw, 16'($urandom), $urandom, 1'b0, 1'b1);
      waitDone(5000);
    end

    $display("[TB] NACK read times out");
    nack_mode = 1'b1;
    applyStimulus(1'b1, 16'h0010, 32'd0, 1'b1, 1'b1);
    waitDone(3000);
    checkOutput("nack_latency", 64'(last_lat >= 1990 && last_lat <= 2100), 64'(1));
    checkOutput("nack_ctrl_en", 64'(bus.o_ctrl[0]), 64'(0));
    nack_mode = 1'b0;
    repeat (10) @(posedge clk);

    $display("[TB] second request while busy is ignored");
    d0 = done_count;
    t0 = txn_count;
    applyStimulus(1'b0, 16'h0040, 32'h01020304, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    applyStimulus(1'b1, 16'h0050, 32'd0, 1'b0, 1'b0);
    waitDone(5000);
    repeat (100) @(posedge clk);
    checkOutput("ignored_done_count", 64'(done_count - d0), 64'(1));
    checkOutput("ignored_txn_count", 64'(txn_count - t0), 64'(1));

    $display("[TB] reset mid-read");
    rd_b[0] = 8'h12; rd_b[1] = 8'h34; rd_b[2] = 8'h56; rd_b[3] = 8'h78;
    applyStimulus(1'b1, 16'h0200, 32'd0, 1'b0, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.o_ctrl[0] && n < 20) begin
        @(posedge clk);
        n++;
      end
      checkOutput("enable_seen", 64'(bus.o_ctrl[0]), 64'(1));
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ctrl", 64'(bus.o_ctrl), 64'(0));
    checkOutput("midrst_busy", 64'(bus.o_busy), 64'(0));
    exp_q.delete();
    model_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = txn_count;
    repeat (40) @(posedge clk);
    checkOutput("no_reissue", 64'(txn_count - t0), 64'(0));
    checkOutput("post_rst_rdata", 64'(bus.o_rdata), 64'(0));
    applyStimulus(1'b1, 16'h0200, 32'd0, 1'b0, 1'b1);
    waitDone(5000);
    checkOutput("post_rst_read", 64'(bus.o_rdata), 64'(32'h12345678));
    checkOutput("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eeprom_cmd_sequencer.md
EEPROM_CMD_SEQUENCER -- requirements
Module: eeprom_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h50, EEPROM 7-bit device address driven on o_dev_addr.
REQ-002 SHALL have parameter CLK_RATE, default 3'd7, I2C rate code driven on o_ctrl[6:4].
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, i_clk cycles allowed per transaction phase.
REQ-004 SHALL have parameter TWR_CYCLES, default 500000, i_clk cycles of EEPROM write-cycle wait (5 ms at 100 MHz).
REQ-005 SHALL use reset i_rst_n, asynchronous, active-low, and clock i_clk.
REQ-006 SHALL have ports: i_clk in 1 system clock; i_rst_n in 1 reset; i_req in 1 request strobe; i_rw in 1 (0 write, 1 read); i_addr in 16 EEPROM word address; i_wdata in 32 write word.
REQ-007 SHALL have ports: o_busy out 1; o_done out 1 one-cycle completion pulse; o_err out 1 one-cycle error pulse; o_rdata out 32 read word.
REQ-008 SHALL have I2C-controller-facing ports: o_ctrl out 32; o_dev_addr out 7; o_reg_addr out 16; o_w_data out 32; i_status in 32; i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4 in 8 each.

Function
REQ-009 SHALL drive o_ctrl[0] as enable, o_ctrl[3:1] as op mode (0 write, 1 read), o_ctrl[6:4] = CLK_RATE, all other o_ctrl bits 0.
REQ-010 SHALL pass i_status[1] (finish) and each bit of i_status[9:2] (controller state) through 2-flop synchronizers before use; "ctrl idle" = synchronized state field 0 for 2 consecutive cycles.
REQ-011 SHALL accept i_req only when o_busy=0, latching i_rw, i_addr, i_wdata; o_busy SHALL go high the next cycle; i_req while busy is ignored.
REQ-012 SHALL implement states IDLE, ISSUE, WAIT_FIN, RELEASE, TWR, DONE.
REQ-013 IDLE -> ISSUE on accepted request; ISSUE drives o_reg_addr/o_w_data/op mode and sets o_ctrl[0]=1, then -> WAIT_FIN next cycle.
REQ-014 WAIT_FIN SHALL hold o_ctrl[0]=1 until a synchronized finish rising edge, then clear o_ctrl[0] and -> RELEASE.
REQ-015 On the finish rising edge of a read, o_rdata SHALL load {i_rd_data, i_rd_data_2, i_rd_data_3, i_rd_data_4} (first received byte in [31:24]); o_rdata otherwise holds.
REQ-016 Write byte order: o_w_data = latched i_wdata, so [31:24] is transmitted first at i_addr.
REQ-017 RELEASE SHALL keep o_ctrl[0]=0 until synchronized finish=0 and ctrl idle, then -> TWR for a successful write, else -> DONE.
REQ-018 TWR SHALL count TWR_CYCLES i_clk cycles with o_ctrl[0]=0, then -> DONE.
REQ-019 DONE SHALL pulse o_done for one cycle (o_err with it if error flagged), clear o_busy the same cycle, -> IDLE.
REQ-020 Timeout counter SHALL reset on entering ISSUE and RELEASE; reaching TIMEOUT_CYCLES in WAIT_FIN SHALL set the error flag, clear o_ctrl[0], -> RELEASE; reaching it in RELEASE SHALL set the error flag and -> DONE (TWR skipped).
REQ-021 A NACKed transfer never raises finish; it SHALL be reported only via timeout, with o_rdata unchanged.
REQ-022 o_dev_addr SHALL be DEV_ADDR constantly.

Reset
REQ-023 On i_rst_n low, state SHALL be IDLE and o_ctrl, o_reg_addr, o_w_data, o_rdata, o_busy, o_done, o_err, counters, synchronizers, error flag SHALL be 0, effective immediately.
REQ-024 Reset mid-transaction SHALL drop o_ctrl[0] at once; after release no request is reissued.

Configuration
REQ-025 Macro EEPROM_TWR_WAIT_EN: defined -> TWR state exists and writes wait TWR_CYCLES; undefined -> RELEASE goes directly to DONE for writes, TWR and its counter are absent.

Verification
REQ-026 Write i_addr=16'h0010, i_wdata=32'hDEADBEEF, ACKing EEPROM model -> bus bytes A0,00,10,DE,AD,BE,EF; o_done after TWR_CYCLES (macro on); o_err=0.
REQ-027 Read i_addr=16'h0010, model returns DE,AD,BE,EF -> o_rdata=32'hDEADBEEF, one o_done pulse, o_err=0.
REQ-028 Model NACKs address, TIMEOUT_CYCLES=2000 -> o_done and o_err pulse together ~2000 cycles after issue; o_rdata unchanged; o_ctrl[0]=0.
REQ-029 Second i_req during busy write -> ignored; exactly one transaction and one o_done.
REQ-030 Assert i_rst_n=0 mid-read -> o_ctrl=0, o_busy=0 immediately; next read after reset completes correctly.
REQ-031 Macro undefined, write -> o_done within 10 cycles of controller returning idle.
